// File: rtl/lsu_ctrl_if.sv
// EXU request/response and data-memory strobe bundle for lsu_ctrl.
// The LSU uses the slave modport; the EXU/memory side uses the master modport.
interface lsu_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int SIZE_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [SIZE_W-1:0] req_size;
  logic              req_store;
  logic              req_unsigned;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_ren;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_raddr;
  logic [XLEN-1:0]   mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [SIZE_W-1:0] mem_size;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, req_store, req_unsigned,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_size
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_size, req_store, req_unsigned,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_size
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control: one transaction in flight, single-cycle memory strobes, load 3 / store 2 cycles to response.
// LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and answer with resp_err; otherwise issued unchanged.
module lsu_ctrl #(
  parameter int XLEN   = 64,
  parameter int SIZE_W = 2
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q, rdata_d;
  logic [SIZE_W-1:0] size_q;
  logic              store_q, uns_q, err_q;
  logic              trap_w, accept_w;

  function automatic logic [XLEN-1:0] mask_to_size(input logic [XLEN-1:0] d,
                                                   input logic [SIZE_W-1:0] s);
    case (s)
      2'd0:    mask_to_size = {{(XLEN-8){1'b0}}, d[7:0]};
      2'd1:    mask_to_size = {{(XLEN-16){1'b0}}, d[15:0]};
      2'd2:    mask_to_size = {{(XLEN-32){1'b0}}, d[31:0]};
      default: mask_to_size = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [SIZE_W-1:0] s,
                                             input logic uns);
    case (s)
      2'd0:    extend = {{(XLEN-8){~uns & d[7]}}, d[7:0]};
      2'd1:    extend = {{(XLEN-16){~uns & d[15]}}, d[15:0]};
      2'd2:    extend = {{(XLEN-32){~uns & d[31]}}, d[31:0]};
      default: extend = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (bus.req_size)
      2'd1:    trap_w = bus.req_addr[0];
      2'd2:    trap_w = |bus.req_addr[1:0];
      2'd3:    trap_w = |bus.req_addr[2:0];
      default: trap_w = 1'b0;
    endcase
  end
`else
  assign trap_w = 1'b0;
`endif

  assign accept_w = (state_q == IDLE) && bus.req_valid;
  // Memory returns a zero-extended slice; sign is rebuilt here from the latched size.
  assign rdata_d  = extend(bus.mem_rdata, size_q, uns_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = trap_w ? RESP : ACC;
      ACC:  state_d = store_q ? RESP : WAIT;
      WAIT: state_d = RESP;
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept_w) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      store_q <= bus.req_store;
      uns_q   <= bus.req_unsigned;
      rdata_q <= '0;
      err_q   <= trap_w;
    end else if (state_q == WAIT) begin
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_raddr  = '0;
    bus.mem_waddr  = '0;
    bus.mem_wdata  = '0;
    bus.mem_size   = '0;
    if (state_q == ACC) begin
      if (store_q) begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = addr_q;
        bus.mem_wdata = mask_to_size(wdata_q, size_q);
      end else begin
        bus.mem_ren   = 1'b1;
        bus.mem_raddr = addr_q;
      end
    end
    if (state_q == ACC || state_q == WAIT) bus.mem_size = size_q;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl; the driver pushes expected responses and strobes,
// independent monitors pop and compare at the negedge.
module tb_lsu_ctrl;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(XLEN)) bus ();
  lsu_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;
  typedef struct {
    logic        store;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } strb_t;

  resp_t       resp_q[$];
  strb_t       strb_q[$];
  logic [63:0] mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    if (s == 2'd3) return {64{1'b1}};
    return (64'd1 << (8 * (1 << s))) - 64'd1;
  endfunction

  // Load result as an integer: value of the slice, minus 2^bits when read as a negative signed number.
  function automatic logic [63:0] model_load(input logic [63:0] val, input logic [1:0] s, input logic uns);
    logic [63:0] v;
    int          bits;
    bits = 8 * (1 << s);
    v = val & size_mask(s);
    if (s != 2'd3 && !uns && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v;
  endfunction

  function automatic bit misaligned(input logic [63:0] addr, input logic [1:0] s);
    return (int'(addr[2:0]) % (1 << s)) != 0;
  endfunction

  // Memory model: a read strobe seen in one cycle is answered during the next one; otherwise garbage.
  logic        ren_pend = 1'b0;
  logic [63:0] pend_val = '0;
  always @(negedge clk) begin
    if (ren_pend) bus.mem_rdata = pend_val;
    else          bus.mem_rdata = {$urandom, $urandom};
    ren_pend = 1'b0;
    if (bus.mem_ren === 1'b1) begin
      pend_val = (mem_q.size() != 0) ? mem_q.pop_front() : 64'h0;
      ren_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.resp_ready = ($urandom_range(0, 2) == 0);
  end

  logic        in_resp = 1'b0;
  logic [63:0] hold_rdata;
  logic        hold_err;
  logic        ren_prev = 1'b0;
  logic        strb_prev = 1'b0;
  logic [1:0]  prev_size;
  always @(negedge clk) begin
    resp_t e;
    strb_t s;
    if (!rst_n) begin
      in_resp = 1'b0;
      ren_prev = 1'b0;
      strb_prev = 1'b0;
    end else begin
      if (strb_prev) check("strobe_one_cycle", {bus.mem_ren, bus.mem_wen}, 0);
      if (ren_prev)  check("wait_size", bus.mem_size, prev_size);
      if (bus.req_ready) check("idle_size", bus.mem_size, 0);
      if (bus.mem_ren || bus.mem_wen) begin
        check("strobe_excl", bus.mem_ren & bus.mem_wen, 0);
        if (strb_q.size() == 0) begin
          check("unexpected_strobe", {bus.mem_ren, bus.mem_wen}, 0);
        end else begin
          s = strb_q.pop_front();
          check("strobe_kind", bus.mem_wen, s.store);
          if (s.store) begin
            check("waddr", bus.mem_waddr, s.addr);
            check("wdata", bus.mem_wdata, s.data);
          end else begin
            check("raddr", bus.mem_raddr, s.addr);
          end
          check("acc_size", bus.mem_size, s.size);
        end
      end
      strb_prev = bus.mem_ren | bus.mem_wen;
      ren_prev  = bus.mem_ren;
      prev_size = bus.mem_size;

      if (bus.resp_valid) begin
        check("req_ready_busy", bus.req_ready, 0);
        if (!in_resp) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", bus.resp_valid, 0);
          end else begin
            e = resp_q.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_err", bus.resp_err, e.err);
            check("resp_latency", 64'(cyc), 64'(e.cyc));
          end
          hold_rdata = bus.resp_rdata;
          hold_err   = bus.resp_err;
          in_resp    = 1'b1;
        end else begin
          check("hold_rdata", bus.resp_rdata, hold_rdata);
          check("hold_err", bus.resp_err, hold_err);
        end
        if (bus.resp_ready) in_resp = 1'b0;
      end
    end
  end

  // Presents a request and holds it until accepted; it stays asserted afterwards while the LSU is busy.
  task automatic issue(input logic [63:0] addr, input logic [63:0] wdata, input logic [1:0] size,
                       input logic store, input logic uns, input logic [63:0] memval, input bit want_resp);
    int    guard;
    bit    trap;
    resp_t r;
    strb_t s;
    @(negedge clk);
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_store    = store;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("req_accept_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      return;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    trap = misaligned(addr, size);
`else
    trap = 1'b0;
`endif
    // Response appears 0/1/2 edges after the accept edge for trap/store/load.
    r.err   = trap;
    r.rdata = (trap || store) ? 64'h0 : model_load(memval, size, uns);
    r.cyc   = cyc + 1 + (trap ? 0 : (store ? 1 : 2));
    if (want_resp) resp_q.push_back(r);
    if (!trap) begin
      s.store = store;
      s.addr  = addr;
      s.data  = wdata & size_mask(size);
      s.size  = size;
      strb_q.push_back(s);
      if (!store) mem_q.push_back(memval);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((resp_q.size() != 0 || strb_q.size() != 0 || bus.resp_valid) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain_queues", 64'(resp_q.size() + strb_q.size()), 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a, mv;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_size = '0;
    bus.req_store = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.resp_ready = 1'b0;
    bus.mem_rdata = '0;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_strobes", {bus.mem_ren, bus.mem_wen}, 0);
    check("rst_resp", {bus.resp_err, bus.resp_rdata}, 0);
    check("rst_mem_bus", bus.mem_raddr | bus.mem_waddr | bus.mem_wdata | 64'(bus.mem_size), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(64'h80000008, 64'h0, 2'd3, 1'b0, 1'b0, 64'h1122334455667788, 1'b1);
    issue(64'h80000003, 64'h0, 2'd0, 1'b0, 1'b0, 64'h80, 1'b1);
    issue(64'h80000003, 64'h0, 2'd0, 1'b0, 1'b1, 64'h80, 1'b1);
    issue(64'h80000002, 64'hDEADBEEFCAFE1234, 2'd1, 1'b1, 1'b0, 64'h0, 1'b1);
    issue(64'h80000002, 64'h0, 2'd2, 1'b0, 1'b0, 64'h89ABCDEF, 1'b1);
    issue(64'h80000004, 64'h0, 2'd2, 1'b0, 1'b1, 64'hF0000001, 1'b1);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'h80000000 | 64'($urandom_range(0, 255));
      mv = {$urandom, $urandom} & size_mask(sz);
      issue(a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mv, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();

    // Reset while the load sits in WAIT: its response must never appear.
    issue(64'h80000010, 64'h0, 2'd3, 1'b0, 1'b0, 64'hCAFEF00D12345678, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_size", bus.mem_size, 3);
    rst_n = 1'b0;
    #1;
    check("arst_req_ready", bus.req_ready, 1);
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_strobes", {bus.mem_ren, bus.mem_wen, bus.mem_size}, 0);
    check("arst_resp", {bus.resp_err, bus.resp_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.req_ready, 1);
    issue(64'h80000020, 64'h0, 2'd1, 1'b0, 1'b0, 64'h8001, 1'b1);
    issue(64'h80000021, 64'h55AA, 2'd0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
    check("mem_queue_empty", 64'(mem_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
